// File: rtl/fb_pkg.sv
// Shared framebuffer constants, pixel/command types and the rectangle writer state set.
// Also imported by the display controller so both sides agree on geometry.
package fb_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int FB_AW = 19;
  localparam int FB_DW = 9;
  localparam int XW    = 10;
  localparam int YW    = 9;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    rgb333_t       colour;
  } rect_cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WRITE, ST_FINISH} fb_state_e;

  // y*640 built from shifts: 640 = 512 + 128
  function automatic logic [FB_AW-1:0] row_base_of(input logic [YW-1:0] y);
    logic [FB_AW-1:0] yw;
    yw = FB_AW'(y);
    return (yw << 9) + (yw << 7);
  endfunction
endpackage

// File: rtl/fb_rect_writer_if.sv
// Command and video-RAM write bundle for fb_rect_writer.
// slave = the writer; master = command source plus RAM/arbiter side.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [XW-1:0]    cmd_x0;
  logic [YW-1:0]    cmd_y0;
  logic [XW-1:0]    cmd_x1;
  logic [YW-1:0]    cmd_y1;
  logic [FB_DW-1:0] cmd_colour;
  logic             busy;
  logic             done;
  logic             wr_en;
  logic [FB_AW-1:0] wr_addr;
  logic [FB_DW-1:0] wr_data;
  logic             wr_ack;
  logic             vblank;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, wr_ack, vblank,
    output cmd_ready, busy, done, wr_en, wr_addr, wr_data
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, wr_ack, vblank,
    input  cmd_ready, busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/fb_addr_gen.sv
// Raster walker for one rectangle: row_base/x/y registers with stride-add row stepping.
// x1_i/y1_i are expected already clamped to the visible area.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [XW-1:0]    x0_i,
  input  logic [YW-1:0]    y0_i,
  input  logic [XW-1:0]    x1_i,
  input  logic [YW-1:0]    y1_i,
  output logic [FB_AW-1:0] addr_o,
  output logic             last_o
);
  logic [FB_AW-1:0] row_base_q, row_base_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_base_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      row_base_q <= row_base_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    row_base_d = row_base_q;
    x_d        = x_q;
    y_d        = y_q;
    if (load_i) begin
      row_base_d = row_base_of(y0_i);
      x_d        = x0_i;
      y_d        = y0_i;
    end else if (advance_i) begin
      if (x_q < x1_i) begin
        x_d = x_q + XW'(1);
      end else if (y_q < y1_i) begin
        x_d        = x0_i;
        y_d        = y_q + YW'(1);
        row_base_d = row_base_q + FB_AW'(H_RES);
      end
    end
  end

  assign addr_o = row_base_q + FB_AW'(x_q);
  assign last_o = (x_q >= x1_i) && (y_q >= y1_i);
endmodule

// File: rtl/fb_rect_writer.sv
// Fills an axis-aligned RGB333 rectangle into the 640x480 video RAM, one pixel per acked write.
// Define FB_RECT_VBLANK_ONLY_EN to gate writes to vertical blank (tear-free updates).
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  fb_rect_writer_if.slave  bus
);
  fb_state_e        state_q, state_d;
  rect_cmd_t        cmd_q, cmd_d;
  logic             live_q;
  logic [XW-1:0]    x1_clamp;
  logic [YW-1:0]    y1_clamp;
  logic             degenerate;
  logic             wr_en;
  logic             wr_fire;
  logic             load;
  logic             advance;
  logic             last;
  logic [FB_AW-1:0] addr;

  assign x1_clamp   = (cmd_q.x1 > XW'(H_RES - 1)) ? XW'(H_RES - 1) : cmd_q.x1;
  assign y1_clamp   = (cmd_q.y1 > YW'(V_RES - 1)) ? YW'(V_RES - 1) : cmd_q.y1;
  assign degenerate = (cmd_q.x0 > x1_clamp) || (cmd_q.y0 > y1_clamp);

`ifdef FB_RECT_VBLANK_ONLY_EN
  assign wr_en = (state_q == ST_WRITE) && bus.vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign wr_en = (state_q == ST_WRITE);
`endif
  assign wr_fire = wr_en && bus.wr_ack;

  // live_q keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && live_q) begin
          cmd_d.x0     = bus.cmd_x0;
          cmd_d.y0     = bus.cmd_y0;
          cmd_d.x1     = bus.cmd_x1;
          cmd_d.y1     = bus.cmd_y1;
          cmd_d.colour = rgb333_t'(bus.cmd_colour);
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (degenerate) begin
          state_d = ST_FINISH;
        end else begin
          load    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          advance = 1'b1;
          if (last) state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  fb_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .advance_i (advance),
    .x0_i      (cmd_q.x0),
    .y0_i      (cmd_q.y0),
    .x1_i      (x1_clamp),
    .y1_i      (y1_clamp),
    .addr_o    (addr),
    .last_o    (last)
  );

  assign bus.cmd_ready = live_q && (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FINISH);
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = addr;
  assign bus.wr_data   = cmd_q.colour;
endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed and randomized rectangle fills checked against a raster-order address model.
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fb_rect_writer_if bus ();
  fb_rect_writer dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ack_mode: 0 = ack always high, 1 = random ack, 2 = ack low for the first 3 write cycles
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input int col, input int ack_mode, input string tag);
    int xe, ye, n, i, writes, stalls, done_at;
    logic prev_hold, exp_en;
    logic [31:0] prev_addr, prev_data;
    exp_q.delete();
    got_addr.delete();
    got_data.delete();
    xe = (x1 > H_RES - 1) ? H_RES - 1 : x1;
    ye = (y1 > V_RES - 1) ? V_RES - 1 : y1;
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++)
        exp_q.push_back(y * H_RES + x);
    n = exp_q.size();

    @(negedge clk);
    bus.cmd_x0     = 10'(x0);
    bus.cmd_y0     = 9'(y0);
    bus.cmd_x1     = 10'(x1);
    bus.cmd_y1     = 9'(y1);
    bus.cmd_colour = 9'(col);
    bus.cmd_valid  = 1'b1;
    #1 check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);

    writes = 0; stalls = 0; done_at = 0; prev_hold = 1'b0;
    prev_addr = '0; prev_data = '0;
    i = 1;
    while (i <= 4 * n + 60 && done_at == 0) begin
      @(negedge clk);
      case (ack_mode)
        0:       bus.wr_ack = 1'b1;
        1:       bus.wr_ack = ($urandom_range(0, 9) < 6);
        default: bus.wr_ack = (i >= 5);
      endcase
      bus.vblank = ($urandom_range(0, 3) != 0);
      #1;
      if (i == 1) begin
        check({tag, "_setup_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_setup_ready"}, 32'(bus.cmd_ready), 32'd0);
      end
      if (bus.done) begin
        done_at = i;
        check({tag, "_finish_wr_en"}, 32'(bus.wr_en), 32'd0);
      end else if (i >= 2 && bus.busy) begin
`ifdef FB_RECT_VBLANK_ONLY_EN
        exp_en = bus.vblank;
`else
        exp_en = 1'b1;
`endif
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'(exp_en));
        if (prev_hold) begin
          check({tag, "_hold_addr"}, 32'(bus.wr_addr), prev_addr);
          check({tag, "_hold_data"}, 32'(bus.wr_data), prev_data);
        end
        if (bus.wr_en && bus.wr_ack) begin
          got_addr.push_back(32'(bus.wr_addr));
          got_data.push_back(32'(bus.wr_data));
          writes++;
          prev_hold = 1'b0;
        end else begin
          stalls++;
          prev_hold = 1'b1;
          prev_addr = 32'(bus.wr_addr);
          prev_data = 32'(bus.wr_data);
        end
      end else begin
        check({tag, "_idle_wr_en"}, 32'(bus.wr_en), 32'd0);
      end
      i++;
    end
    bus.cmd_valid = 1'b0;

    check({tag, "_n_writes"}, 32'(got_addr.size()), 32'(n));
    for (int k = 0; k < n && k < got_addr.size(); k++) begin
      check({tag, "_addr"}, got_addr[k], exp_q[k]);
      check({tag, "_data"}, got_data[k], 32'(col & 'h1FF));
    end
    check({tag, "_done_at"}, 32'(done_at), 32'(2 + writes + stalls));

    @(negedge clk);
    #1;
    check({tag, "_post_done"}, 32'(bus.done), 32'd0);
    check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_post_wr_en"}, 32'(bus.wr_en), 32'd0);
  endtask

  int acks;
  int cyc;
  int rx0, ry0, rx1, ry1;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_x0     = '0;
    bus.cmd_y0     = '0;
    bus.cmd_x1     = '0;
    bus.cmd_y1     = '0;
    bus.cmd_colour = '0;
    bus.wr_ack     = 1'b0;
    bus.vblank     = 1'b1;

    #12;
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rel_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1 check("rel_ready_high", 32'(bus.cmd_ready), 32'd1);

    run_cmd(5, 3, 5, 3, 'h1FF, 0, "single");
    run_cmd(638, 478, 639, 479, 'h0A5, 0, "corner");
    run_cmd(637, 0, 1000, 0, 'h123, 0, "clamp_x");
    run_cmd(0, 478, 1, 511, 'h03C, 1, "clamp_y");
    run_cmd(10, 5, 9, 5, 'h111, 0, "degen");
    run_cmd(700, 2, 800, 2, 'h0F0, 0, "degen_x0");
    run_cmd(0, 0, 1, 0, 'h155, 2, "stall");

    for (int t = 0; t < 10; t++) begin
      rx0 = $urandom_range(0, 639);
      ry0 = $urandom_range(0, 479);
      rx1 = ($urandom_range(0, 7) == 0) ? $urandom_range(640, 1023) : rx0 + $urandom_range(0, 5);
      ry1 = ry0 + $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0 && rx0 > 0) rx1 = rx0 - 1;
      run_cmd(rx0, ry0, rx1, ry1, $urandom_range(0, 511), $urandom_range(0, 1), "rand");
    end

    // Full-screen fill aborted by reset after 100 accepted writes
    @(negedge clk);
    bus.cmd_x0 = 10'd0; bus.cmd_y0 = 9'd0;
    bus.cmd_x1 = 10'd639; bus.cmd_y1 = 9'd479;
    bus.cmd_colour = 9'h0AA;
    bus.cmd_valid = 1'b1;
    bus.wr_ack = 1'b1;
    bus.vblank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    acks = 0;
    cyc = 0;
    while (acks < 100 && cyc < 400) begin
      @(negedge clk);
      #1;
      if (bus.wr_en && bus.wr_ack) acks++;
      cyc++;
    end
    check("abort_acks", 32'(acks), 32'd100);
    check("abort_pre_wr_en", 32'(bus.wr_en), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_wr_en", 32'(bus.wr_en), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_ready", 32'(bus.cmd_ready), 32'd0);
    check("abort_addr", 32'(bus.wr_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("abort_done_hold", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_rel_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("abort_rel_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_rel_done", 32'(bus.done), 32'd0);
    bus.wr_ack = 1'b0;

    run_cmd(2, 1, 4, 2, 'h1C7, 1, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
